pcm_i2s_tx: RTL

PCM output stage that drains decoded stereo samples from the MP3 decoder's output FIFO (HCLK read side) and serialises them as a standard Philips I2S stream. It sits directly downstream of the decoder's AHB wrapper: it pops one 32-bit word (left in [31:16], right in [15:0]) per audio frame and generates BCLK, LRCK and SDATA from HCLK with a programmable divider. FIFO underruns produce silence and are counted for the wrapper's status register.

---
 rtl/pcm_i2s_tx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pcm_i2s_tx.sv
// Philips I2S transmitter for 16-bit stereo PCM, drained from a show-ahead FIFO.
// BCLK, LRCK and SDATA are generated from HCLK by a programmable half-period divider.
module pcm_i2s_tx (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        enable,
   input  logic [7:0]  clkdiv,
   input  logic [31:0] pcm_data,
   input  logic        pcm_valid,
   output logic        pcm_ready,
   input  logic        underrun_clr,
   output logic        i2s_bclk,
   output logic        i2s_lrck,
   output logic        i2s_sdata,
   output logic        underrun,
   output logic [15:0] underrun_cnt
);

   logic        enable_q;
   logic [7:0]  clkdiv_q;
   logic [7:0]  div_cnt;
   logic [7:0]  div_lim;
   logic [4:0]  fc;
   logic [4:0]  fc_nxt;
   logic [31:0] hold;
   logic        hold_full;
   logic [31:0] shifter;
   logic [31:0] shifter_nxt;
   logic        tick;
   logic        fall;
   logic        load;
   logic        silent;

   assign pcm_ready = enable & pcm_valid & ~hold_full;

   // On the first enabled cycle the divider must already obey the new clkdiv,
   // so the compare uses the input until clkdiv_q has been captured.
   always_comb begin
      div_lim     = enable_q ? clkdiv_q : clkdiv;
      tick        = enable && (div_cnt == div_lim);
      fall        = tick && i2s_bclk;
      fc_nxt      = fc + 5'd1;
      load        = fall && (fc_nxt == 5'd1);
      silent      = load && !hold_full;
      shifter_nxt = {shifter[30:0], 1'b0};
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         enable_q <= 1'b0;
         clkdiv_q <= 8'd0;
      end else begin
         enable_q <= enable;
         if (enable && !enable_q)
            clkdiv_q <= clkdiv;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         div_cnt   <= 8'd0;
         fc        <= 5'd31;
         i2s_bclk  <= 1'b0;
         i2s_lrck  <= 1'b0;
         i2s_sdata <= 1'b0;
         shifter   <= 32'd0;
      end else if (!enable) begin
         div_cnt   <= 8'd0;
         fc        <= 5'd31;
         i2s_bclk  <= 1'b0;
         i2s_lrck  <= 1'b0;
         i2s_sdata <= 1'b0;
         shifter   <= 32'd0;
      end else if (tick) begin
         div_cnt  <= 8'd0;
         i2s_bclk <= ~i2s_bclk;
         if (i2s_bclk) begin
            fc       <= fc_nxt;
            i2s_lrck <= fc_nxt[4];
            // Data is loaded one BCLK after LRCK changes, giving the I2S one-bit delay.
            if (fc_nxt == 5'd1) begin
               if (hold_full) begin
                  shifter   <= hold;
                  i2s_sdata <= hold[31];
               end else begin
                  shifter   <= 32'd0;
                  i2s_sdata <= 1'b0;
               end
            end else begin
               shifter   <= shifter_nxt;
               i2s_sdata <= shifter_nxt[31];
            end
         end
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

   // pcm_ready excludes hold_full, so a refill and a frame load never collide.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold      <= 32'd0;
         hold_full <= 1'b0;
      end else if (pcm_ready) begin
         hold      <= pcm_data;
         hold_full <= 1'b1;
      end else if (load && hold_full) begin
         hold_full <= 1'b0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         underrun     <= 1'b0;
         underrun_cnt <= 16'd0;
      end else begin
         underrun <= silent;
         if (underrun_clr)
            underrun_cnt <= silent ? 16'd1 : 16'd0;
         else if (silent && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
      end
   end

endmodule
